// File: rtl/segment_transition_ctl.sv
// Purpose: segment sequencer for the double-buffered MOD/STM read path (optional GPIO trigger: SEGMENT_TRANSITION_GPIO_EN).
// Latency: UPDATE_SETTINGS to PENDING/ERR 1 cycle; transition condition to SEGMENT/START 1 cycle.
// Backpressure: none; requests are single-cycle pulses, and a newer request replaces a pending one.
module segment_transition_ctl #(
  parameter int CYCLE_WIDTH    = 15,
  parameter int REP_WIDTH      = 16,
  parameter int SYS_TIME_WIDTH = 56
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      UPDATE_SETTINGS,
  input  logic                      REQ_RD_SEGMENT,
  input  logic [CYCLE_WIDTH-1:0]    REQ_CYCLE,
  input  logic [REP_WIDTH-1:0]      REQ_REP,
  input  logic [7:0]                TRANSITION_MODE,
  input  logic [63:0]               TRANSITION_VALUE,
  input  logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
  input  logic [3:0]                GPIO_IN,
  input  logic                      IDX_UPDATE,
  input  logic [CYCLE_WIDTH-1:0]    IDX,
  output logic                      SEGMENT,
  output logic                      START,
  output logic                      STOP,
  output logic                      PENDING,
  output logic                      ERR
);

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;
  localparam logic [REP_WIDTH-1:0] REP_INF = '1;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t                    state_q, state_d;
  logic                      seg_q, seg_d;
  logic                      start_q, start_d;
  logic                      stop_q, stop_d;
  logic                      pending_q, pending_d;
  logic                      err_q, err_d;
  logic                      alt_q, alt_d;
  logic [CYCLE_WIDTH-1:0]    act_cycle_q, act_cycle_d;
  logic [REP_WIDTH-1:0]      act_rep_q, act_rep_d;
  logic [REP_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      req_seg_q, req_seg_d;
  logic [CYCLE_WIDTH-1:0]    req_cycle_q, req_cycle_d;
  logic [REP_WIDTH-1:0]      req_rep_q, req_rep_d;
  logic [7:0]                req_mode_q, req_mode_d;
  logic [SYS_TIME_WIDTH-1:0] req_value_q, req_value_d;

  logic mode_ok;
  logic loop_end;
  logic switch_cond;
  logic unused_ok;

  // The active segment wraps when the sampler lands on its last index
  assign loop_end = IDX_UPDATE && (IDX == act_cycle_q);

`ifdef SEGMENT_TRANSITION_GPIO_EN
  logic [3:0] gpio_q, gpio_qq;
  logic       gpio_rise;

  // GPIO_IN is registered once; edges are taken between the registered copy and its previous value
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      gpio_q  <= '0;
      gpio_qq <= '0;
    end else begin
      gpio_q  <= GPIO_IN;
      gpio_qq <= gpio_q;
    end
  end

  assign gpio_rise = gpio_q[req_value_q[1:0]] & ~gpio_qq[req_value_q[1:0]];
  assign unused_ok = ^TRANSITION_VALUE[63:SYS_TIME_WIDTH];
`else
  assign unused_ok = ^{TRANSITION_VALUE[63:SYS_TIME_WIDTH], GPIO_IN};
`endif

  // Classify the incoming request mode
  always_comb begin
    mode_ok = 1'b0;
    case (TRANSITION_MODE)
      MODE_SYNC_IDX, MODE_SYS_TIME, MODE_EXT: mode_ok = 1'b1;
`ifdef SEGMENT_TRANSITION_GPIO_EN
      MODE_GPIO: mode_ok = 1'b1;
`endif
      default: mode_ok = 1'b0;
    endcase
  end

  // Transition condition of the pending request
  always_comb begin
    switch_cond = 1'b0;
    case (req_mode_q)
      MODE_SYNC_IDX, MODE_EXT: switch_cond = loop_end;
      MODE_SYS_TIME:           switch_cond = (SYS_TIME >= req_value_q);
`ifdef SEGMENT_TRANSITION_GPIO_EN
      MODE_GPIO:               switch_cond = gpio_rise;
`endif
      default:                 switch_cond = 1'b0;
    endcase
  end

  // Next-state: new requests take priority over a switch, a switch over loop counting
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    start_d     = 1'b0;
    stop_d      = stop_q;
    pending_d   = pending_q;
    err_d       = err_q;
    alt_d       = alt_q;
    act_cycle_d = act_cycle_q;
    act_rep_d   = act_rep_q;
    cnt_d       = cnt_q;
    req_seg_d   = req_seg_q;
    req_cycle_d = req_cycle_q;
    req_rep_d   = req_rep_q;
    req_mode_d  = req_mode_q;
    req_value_d = req_value_q;

    if (UPDATE_SETTINGS) begin
      err_d = ~mode_ok;
      alt_d = 1'b0;
      if (mode_ok) begin
        if (REQ_RD_SEGMENT == seg_q) begin
          // Same segment: restart it in place with the new bounds
          act_cycle_d = REQ_CYCLE;
          act_rep_d   = REQ_REP;
          cnt_d       = '0;
          stop_d      = 1'b0;
          start_d     = 1'b1;
          alt_d       = (TRANSITION_MODE == MODE_EXT);
          pending_d   = 1'b0;
          state_d     = ST_RUN;
        end else begin
          req_seg_d   = REQ_RD_SEGMENT;
          req_cycle_d = REQ_CYCLE;
          req_rep_d   = REQ_REP;
          req_mode_d  = TRANSITION_MODE;
          req_value_d = TRANSITION_VALUE[SYS_TIME_WIDTH-1:0];
          pending_d   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
    end else if (state_q == ST_WAIT) begin
      if (switch_cond) begin
        seg_d       = req_seg_q;
        start_d     = 1'b1;
        pending_d   = 1'b0;
        stop_d      = 1'b0;
        cnt_d       = '0;
        act_cycle_d = req_cycle_q;
        act_rep_d   = req_rep_q;
        alt_d       = (req_mode_q == MODE_EXT);
        state_d     = ST_RUN;
      end
    end else if (loop_end) begin
      if ((act_rep_q != REP_INF) && (cnt_q == act_rep_q)) begin
        if (alt_q) begin
          // Auto-alternate flips segments instead of stopping; both share the latched bounds
          seg_d   = ~seg_q;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          stop_d = 1'b1;
        end
      end else if (cnt_q != REP_INF) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      seg_q       <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      alt_q       <= 1'b0;
      act_cycle_q <= '0;
      act_rep_q   <= REP_INF;
      cnt_q       <= '0;
      req_seg_q   <= 1'b0;
      req_cycle_q <= '0;
      req_rep_q   <= '0;
      req_mode_q  <= MODE_SYNC_IDX;
      req_value_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      alt_q       <= alt_d;
      act_cycle_q <= act_cycle_d;
      act_rep_q   <= act_rep_d;
      cnt_q       <= cnt_d;
      req_seg_q   <= req_seg_d;
      req_cycle_q <= req_cycle_d;
      req_rep_q   <= req_rep_d;
      req_mode_q  <= req_mode_d;
      req_value_q <= req_value_d;
    end
  end

  assign SEGMENT = seg_q;
  assign START   = start_q;
  assign STOP    = stop_q;
  assign PENDING = pending_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Purpose: directed test-plan walk plus randomized traffic for segment_transition_ctl against a reference model.
// Latency: outputs sampled 1 time unit after each rising CLK edge.
// Backpressure: none; stimulus is driven every cycle.
module tb_segment_transition_ctl;

  localparam int CW = 15;
  localparam int RW = 16;
  localparam int TW = 56;
  localparam logic [RW-1:0] INF = '1;
`ifdef SEGMENT_TRANSITION_GPIO_EN
  localparam bit GPIO_EN = 1'b1;
`else
  localparam bit GPIO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          UPDATE_SETTINGS = 1'b0;
  logic          REQ_RD_SEGMENT = 1'b0;
  logic [CW-1:0] REQ_CYCLE = '0;
  logic [RW-1:0] REQ_REP = '0;
  logic [7:0]    TRANSITION_MODE = '0;
  logic [63:0]   TRANSITION_VALUE = '0;
  logic [TW-1:0] SYS_TIME = '0;
  logic [3:0]    GPIO_IN = '0;
  logic          IDX_UPDATE = 1'b0;
  logic [CW-1:0] IDX = '0;
  logic          SEGMENT, START, STOP, PENDING, ERR;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  segment_transition_ctl #(.CYCLE_WIDTH(CW), .REP_WIDTH(RW), .SYS_TIME_WIDTH(TW)) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE_SETTINGS(UPDATE_SETTINGS), .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
    .REQ_CYCLE(REQ_CYCLE), .REQ_REP(REQ_REP), .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
    .IDX_UPDATE(IDX_UPDATE), .IDX(IDX), .SEGMENT(SEGMENT), .START(START), .STOP(STOP),
    .PENDING(PENDING), .ERR(ERR)
  );

  // Reference model: a pending request record, a loop tally and the visible flags
  typedef struct {
    logic          seg;
    logic [CW-1:0] cyc;
    logic [RW-1:0] rep;
    logic [7:0]    mode;
    logic [63:0]   val;
  } req_t;

  req_t          m_req;
  logic          m_seg, m_start, m_stop, m_pend, m_err, m_alt;
  logic [CW-1:0] m_cyc;
  logic [RW-1:0] m_rep;
  int            m_loops;
  logic [3:0]    m_g1, m_g2;

  function automatic bit supported(input logic [7:0] mode);
    return (mode == 8'h00) || (mode == 8'h01) || (mode == 8'hF0) || (GPIO_EN && mode == 8'h02);
  endfunction

  task automatic model_step();
    bit wrap, cond;
    if (!RST_N) begin
      m_seg = 0; m_start = 0; m_stop = 0; m_pend = 0; m_err = 0; m_alt = 0;
      m_cyc = '0; m_rep = INF; m_loops = 0; m_g1 = '0; m_g2 = '0;
      m_req = '{seg: 1'b0, cyc: '0, rep: '0, mode: 8'h00, val: 64'd0};
      return;
    end
    wrap = IDX_UPDATE && (IDX == m_cyc);
    case (m_req.mode)
      8'h00, 8'hF0: cond = wrap;
      8'h01:        cond = (SYS_TIME >= m_req.val[TW-1:0]);
      8'h02:        cond = GPIO_EN && m_g1[m_req.val[1:0]] && !m_g2[m_req.val[1:0]];
      default:      cond = 0;
    endcase
    m_start = 0;
    if (UPDATE_SETTINGS) begin
      m_alt = 0;
      m_err = !supported(TRANSITION_MODE);
      if (!m_err) begin
        if (REQ_RD_SEGMENT == m_seg) begin
          m_cyc = REQ_CYCLE; m_rep = REQ_REP; m_loops = 0; m_stop = 0; m_start = 1; m_pend = 0;
          m_alt = (TRANSITION_MODE == 8'hF0);
        end else begin
          m_req = '{seg: REQ_RD_SEGMENT, cyc: REQ_CYCLE, rep: REQ_REP, mode: TRANSITION_MODE, val: TRANSITION_VALUE};
          m_pend = 1;
        end
      end
    end else if (m_pend) begin
      if (cond) begin
        m_seg = m_req.seg; m_cyc = m_req.cyc; m_rep = m_req.rep; m_start = 1; m_pend = 0;
        m_stop = 0; m_loops = 0; m_alt = (m_req.mode == 8'hF0);
      end
    end else if (wrap) begin
      // loop number rep+1 is the one that exhausts the repetitions
      m_loops++;
      if (m_rep != INF && m_loops > int'(m_rep)) begin
        if (m_alt) begin
          m_seg = ~m_seg; m_start = 1; m_loops = 0;
        end else begin
          m_stop = 1;
        end
      end
    end
    m_g2 = m_g1;
    m_g1 = GPIO_IN;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    chk("m_segment", SEGMENT, m_seg);
    chk("m_start", START, m_start);
    chk("m_stop", STOP, m_stop);
    chk("m_pending", PENDING, m_pend);
    chk("m_err", ERR, m_err);
  endtask

  task automatic update(input logic seg, input logic [7:0] mode, input logic [63:0] val,
                        input logic [CW-1:0] cyc, input logic [RW-1:0] rep);
    UPDATE_SETTINGS = 1; REQ_RD_SEGMENT = seg; TRANSITION_MODE = mode;
    TRANSITION_VALUE = val; REQ_CYCLE = cyc; REQ_REP = rep;
    tick();
    UPDATE_SETTINGS = 0;
  endtask

  task automatic step(input int i);
    IDX_UPDATE = 1; IDX = CW'(i);
    tick();
    IDX_UPDATE = 0;
  endtask

  logic [63:0] sys_t;

  initial begin
    // Reset
    RST_N = 0;
    tick(); tick();
    chk("rst_segment", SEGMENT, 0); chk("rst_start", START, 0); chk("rst_stop", STOP, 0);
    chk("rst_pending", PENDING, 0); chk("rst_err", ERR, 0);
    RST_N = 1;
    tick();

    // SYNC_IDX: active cycle 4, request segment 1
    update(0, 8'h00, 0, 4, INF);
    chk("reload_start", START, 1);
    update(1, 8'h00, 0, 9, INF);
    chk("sync_pending", PENDING, 1);
    for (int i = 0; i < 4; i++) step(i);
    chk("sync_hold_seg", SEGMENT, 0);
    step(4);
    chk("sync_seg", SEGMENT, 1); chk("sync_start", START, 1); chk("sync_pend_clr", PENDING, 0);
    tick();
    chk("sync_start_pulse", START, 0);

    // SYS_TIME ramp through the target
    update(0, 8'h01, 64'd1000, 5, INF);
    for (int t = 990; t <= 1010; t++) begin
      SYS_TIME = TW'(t);
      tick();
      if (t == 999) chk("time_before", SEGMENT, 1);
      if (t == 1000) begin chk("time_seg", SEGMENT, 0); chk("time_start", START, 1); end
    end
    SYS_TIME = TW'(2000);
    update(1, 8'h01, 64'd5, 3, 2);
    chk("past_pending", PENDING, 1);
    tick();
    chk("past_seg", SEGMENT, 1); chk("past_start", START, 1); chk("past_pend", PENDING, 0);

    // Repeat count: 3 loops of cycle 3 then STOP held
    update(1, 8'h00, 0, 3, 2);
    chk("rep_start", START, 1);
    for (int k = 0; k < 16; k++) begin
      step(k % 4);
      if (k == 10 || k == 11 || k == 15) chk("rep_stop", STOP, (k >= 11) ? 1 : 0);
    end
    update(1, 8'h00, 0, 3, INF);
    chk("rep_stop_clr", STOP, 0); chk("rep_restart", START, 1);

    // EXT auto-alternate with rep 0, cycle 1
    update(0, 8'hF0, 0, 1, 0);
    chk("ext_pending", PENDING, 1);
    for (int i = 0; i < 4; i++) step(i);
    chk("ext_first", SEGMENT, 0); chk("ext_first_start", START, 1);
    for (int r = 0; r < 4; r++) begin
      step(0);
      chk("ext_quiet", START, 0);
      step(1);
      chk("ext_toggle", SEGMENT, (r % 2 == 0) ? 1 : 0); chk("ext_start", START, 1);
    end
    update(0, 8'h00, 0, 1, 0);
    step(0); step(1);
    chk("ext_cancel_stop", STOP, 1); chk("ext_cancel_seg", SEGMENT, 0);

    // GPIO trigger on pin 2
    update(1, 8'h02, 64'd2, 5, INF);
    chk("gpio_err", ERR, GPIO_EN ? 0 : 1);
    chk("gpio_pending", PENDING, GPIO_EN ? 1 : 0);
    GPIO_IN = 4'b0100;
    tick();
    chk("gpio_reg_seg", SEGMENT, 0);
    tick();
    chk("gpio_seg", SEGMENT, GPIO_EN ? 1 : 0);
    GPIO_IN = 4'b0000;
    tick();

    // Unsupported mode, then reset while waiting
    update(0, 8'h07, 0, 2, INF);
    chk("bad_err", ERR, 1); chk("bad_pending", PENDING, 0);
    update(GPIO_EN ? 1'b0 : 1'b1, 8'h00, 0, 2, INF);
    chk("wait_pending", PENDING, 1); chk("wait_err", ERR, 0);
    RST_N = 0;
    tick();
    chk("rstw_seg", SEGMENT, 0); chk("rstw_pend", PENDING, 0); chk("rstw_stop", STOP, 0);
    RST_N = 1;
    tick();

    // Randomized traffic against the model
    sys_t = 64'd3000;
    for (int c = 0; c < 3000; c++) begin
      sys_t = sys_t + 64'd1;
      SYS_TIME = sys_t[TW-1:0];
      RST_N = ($urandom_range(0, 499) != 0);
      UPDATE_SETTINGS = ($urandom_range(0, 11) == 0);
      REQ_RD_SEGMENT = 1'($urandom_range(0, 1));
      REQ_CYCLE = CW'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: REQ_REP = RW'(0);
        1: REQ_REP = RW'(1);
        2: REQ_REP = RW'(2);
        default: REQ_REP = INF;
      endcase
      case ($urandom_range(0, 5))
        0: TRANSITION_MODE = 8'h00;
        1: TRANSITION_MODE = 8'h01;
        2: TRANSITION_MODE = 8'h02;
        3, 4: TRANSITION_MODE = 8'hF0;
        default: TRANSITION_MODE = 8'($urandom_range(3, 255));
      endcase
      TRANSITION_VALUE = sys_t + 64'($urandom_range(0, 40)) - 64'd10;
      IDX_UPDATE = 1'($urandom_range(0, 1));
      IDX = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) GPIO_IN = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
